// File: rtl/channel_reduce_param.sv
// Purpose: fold N words popped from the input FIFO with a fixed operator, push one result word.
// Latency: INIT 1 cycle, READ N cycles, WRITE 1 cycle (no stalls); frame period N+2 in continuous mode.
// Backpressure: empty input FIFO stalls READ without consuming; full output FIFO holds WRITE with data stable.
module channel_reduce_param #(
  parameter int WIDTH      = 32,
  parameter int N          = 4,
  parameter int OP         = 0,
  parameter int CONTINUOUS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_out_data,
  input  logic             in_read_ready,
  input  logic             in_write_ready,
  output logic             in_read_valid,
  output logic [WIDTH-1:0] in_in_data,
  output logic             in_write_valid,
  output logic             in_rst,
  input  logic [WIDTH-1:0] out_out_data,
  input  logic             out_read_ready,
  input  logic             out_write_ready,
  output logic [WIDTH-1:0] out_in_data,
  output logic             out_write_valid,
  output logic             out_read_valid,
  output logic             out_rst,
  output logic             valid
);

  localparam int CW = $clog2(N + 1);
  // min starts from all-ones so the first word always wins; other operators start from zero
  localparam logic [WIDTH-1:0] IDENT = (OP == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_INIT, S_READ, S_WRITE, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_fold;
  logic             w_pop;
  logic             w_push;
  logic             w_unused;

  // Inputs on the unused halves of both channels are deliberately ignored
  assign w_unused = in_write_ready ^ out_read_ready ^ (^out_out_data);

  // Strobes decode from state only; rst forces every output low
  assign in_read_valid   = !rst && (r_state == S_READ);
  assign out_write_valid = !rst && (r_state == S_WRITE);
  assign out_in_data     = rst ? {WIDTH{1'b0}} : r_acc;
  assign valid           = !rst && ((CONTINUOUS != 0) ? ((r_state == S_WRITE) && out_write_ready)
                                                      : (r_state == S_DONE));
  assign in_in_data      = {WIDTH{1'b0}};
  assign in_write_valid  = 1'b0;
  assign in_rst          = 1'b0;
  assign out_read_valid  = 1'b0;
  assign out_rst         = 1'b0;

  assign w_pop  = (r_state == S_READ) && in_read_ready;
  assign w_push = (r_state == S_WRITE) && out_write_ready;

  // Combine the running accumulator with the FIFO head word; compares are unsigned, sum wraps
  always_comb begin
    w_fold = r_acc;
    case (OP)
      1:       w_fold = (in_out_data < r_acc) ? in_out_data : r_acc;
      2:       w_fold = (in_out_data > r_acc) ? in_out_data : r_acc;
      3:       w_fold = r_acc ^ in_out_data;
      default: w_fold = r_acc + in_out_data;
    endcase
  end

  // Frame sequencer: INIT clears, READ folds N pops, WRITE holds result until pushed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_count <= '0;
      r_acc   <= IDENT;
    end else begin
      case (r_state)
        S_INIT: begin
          r_acc   <= IDENT;
          r_count <= '0;
          r_state <= S_READ;
        end
        S_READ: begin
          if (w_pop) begin
            r_acc   <= w_fold;
            r_count <= r_count + 1'b1;
            if (r_count == LAST) r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_push) r_state <= (CONTINUOUS != 0) ? S_INIT : S_DONE;
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_reduce_param.sv
// Bench for channel_reduce_param: several parameterisations share one stimulus stream.
// Table vectors check every operator plus width wrap; hand sequences cover stalls,
// continuous mode and a mid-frame reset.
module tb_channel_reduce_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] d = '0;
  logic        rdy = 1'b0;
  logic        wrdy = 1'b0;

  wire         rv [7];
  wire         wv [7];
  wire         vl [7];
  wire         iwv [7];
  wire         irst [7];
  wire         orv [7];
  wire         orst [7];
  wire [31:0]  od [7];
  wire [31:0]  iid [7];
  wire [7:0]   od1;
  wire [7:0]   iid1;

  assign od[1]  = {24'd0, od1};
  assign iid[1] = {24'd0, iid1};

  always #5 clk = ~clk;

  channel_reduce_param #(.WIDTH(32), .N(4), .OP(0), .CONTINUOUS(0)) u0 (
    .clk(clk), .rst(rst), .in_out_data(d), .in_read_ready(rdy), .in_write_ready(1'b0),
    .in_read_valid(rv[0]), .in_in_data(iid[0]), .in_write_valid(iwv[0]), .in_rst(irst[0]),
    .out_out_data(32'd0), .out_read_ready(1'b0), .out_write_ready(wrdy), .out_in_data(od[0]),
    .out_write_valid(wv[0]), .out_read_valid(orv[0]), .out_rst(orst[0]), .valid(vl[0]));
  channel_reduce_param #(.WIDTH(8), .N(4), .OP(0), .CONTINUOUS(0)) u1 (
    .clk(clk), .rst(rst), .in_out_data(d[7:0]), .in_read_ready(rdy), .in_write_ready(1'b0),
    .in_read_valid(rv[1]), .in_in_data(iid1), .in_write_valid(iwv[1]), .in_rst(irst[1]),
    .out_out_data(8'd0), .out_read_ready(1'b0), .out_write_ready(wrdy), .out_in_data(od1),
    .out_write_valid(wv[1]), .out_read_valid(orv[1]), .out_rst(orst[1]), .valid(vl[1]));
  channel_reduce_param #(.WIDTH(32), .N(4), .OP(1), .CONTINUOUS(0)) u2 (
    .clk(clk), .rst(rst), .in_out_data(d), .in_read_ready(rdy), .in_write_ready(1'b0),
    .in_read_valid(rv[2]), .in_in_data(iid[2]), .in_write_valid(iwv[2]), .in_rst(irst[2]),
    .out_out_data(32'd0), .out_read_ready(1'b0), .out_write_ready(wrdy), .out_in_data(od[2]),
    .out_write_valid(wv[2]), .out_read_valid(orv[2]), .out_rst(orst[2]), .valid(vl[2]));
  channel_reduce_param #(.WIDTH(32), .N(4), .OP(2), .CONTINUOUS(0)) u3 (
    .clk(clk), .rst(rst), .in_out_data(d), .in_read_ready(rdy), .in_write_ready(1'b0),
    .in_read_valid(rv[3]), .in_in_data(iid[3]), .in_write_valid(iwv[3]), .in_rst(irst[3]),
    .out_out_data(32'd0), .out_read_ready(1'b0), .out_write_ready(wrdy), .out_in_data(od[3]),
    .out_write_valid(wv[3]), .out_read_valid(orv[3]), .out_rst(orst[3]), .valid(vl[3]));
  channel_reduce_param #(.WIDTH(32), .N(4), .OP(3), .CONTINUOUS(0)) u4 (
    .clk(clk), .rst(rst), .in_out_data(d), .in_read_ready(rdy), .in_write_ready(1'b0),
    .in_read_valid(rv[4]), .in_in_data(iid[4]), .in_write_valid(iwv[4]), .in_rst(irst[4]),
    .out_out_data(32'd0), .out_read_ready(1'b0), .out_write_ready(wrdy), .out_in_data(od[4]),
    .out_write_valid(wv[4]), .out_read_valid(orv[4]), .out_rst(orst[4]), .valid(vl[4]));
  channel_reduce_param #(.WIDTH(32), .N(4), .OP(0), .CONTINUOUS(1)) u5 (
    .clk(clk), .rst(rst), .in_out_data(d), .in_read_ready(rdy), .in_write_ready(1'b0),
    .in_read_valid(rv[5]), .in_in_data(iid[5]), .in_write_valid(iwv[5]), .in_rst(irst[5]),
    .out_out_data(32'd0), .out_read_ready(1'b0), .out_write_ready(wrdy), .out_in_data(od[5]),
    .out_write_valid(wv[5]), .out_read_valid(orv[5]), .out_rst(orst[5]), .valid(vl[5]));
  channel_reduce_param #(.WIDTH(32), .N(1), .OP(2), .CONTINUOUS(0)) u6 (
    .clk(clk), .rst(rst), .in_out_data(d), .in_read_ready(rdy), .in_write_ready(1'b0),
    .in_read_valid(rv[6]), .in_in_data(iid[6]), .in_write_valid(iwv[6]), .in_rst(irst[6]),
    .out_out_data(32'd0), .out_read_ready(1'b0), .out_write_ready(wrdy), .out_in_data(od[6]),
    .out_write_valid(wv[6]), .out_read_valid(orv[6]), .out_rst(orst[6]), .valid(vl[6]));

  typedef struct packed {
    logic [3:0][31:0] d;
    logic [4:0][31:0] e;   // expected: u0 sum32, u1 sum8, u2 min, u3 max, u4 xor
  } vec_t;

  vec_t        vt [5];
  logic [31:0] fifo [8];

  int          checks = 0;
  int          failures = 0;

  // per-run logs
  int          push_cnt [7];
  int          pop_cnt [7];
  int          vcnt [7];
  int          pcyc [7];
  logic [31:0] pval [7][2];
  int          vfirst;
  bit          conflict, tie_bad, rst_bad, unstable, wseen;
  logic [31:0] wfirst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int v, input logic [31:0] a, b, c, dd,
                         input logic [31:0] e0, e1, e2, e3, e4);
    vt[v].d[0] = a;  vt[v].d[1] = b;  vt[v].d[2] = c;  vt[v].d[3] = dd;
    vt[v].e[0] = e0; vt[v].e[1] = e1; vt[v].e[2] = e2; vt[v].e[3] = e3; vt[v].e[4] = e4;
  endtask

  task automatic scan_rst();
    for (int i = 0; i < 7; i++)
      if (rv[i] || wv[i] || vl[i] || od[i] != 32'd0) rst_bad = 1'b1;
  endtask

  task automatic scan_tie();
    for (int i = 0; i < 7; i++)
      if (iwv[i] || irst[i] || orv[i] || orst[i] || iid[i] != 32'd0) tie_bad = 1'b1;
  endtask

  // Reset for two cycles, then run 'cycles' cycles; cycle 0 is the first cycle with rst low.
  // The FIFO head index advances on pops of instance 'master'.
  task automatic run(input int nw, input int cycles, input int master, input bit toggle,
                     input int wstall, input int rst_at);
    int  k;
    int  wcnt;
    bit  stall;
    for (int i = 0; i < 7; i++) begin
      push_cnt[i] = 0; pop_cnt[i] = 0; vcnt[i] = 0; pcyc[i] = -1;
      pval[i][0] = '0; pval[i][1] = '0;
    end
    vfirst = -1; conflict = 0; tie_bad = 0; rst_bad = 0; unstable = 0; wseen = 0; wfirst = '0;
    k = 0; wcnt = 0;
    @(negedge clk);
    rst = 1'b1; rdy = 1'b0; wrdy = 1'b0; d = '0;
    repeat (2) begin
      @(negedge clk);
      #1;
      scan_rst();
      scan_tie();
    end
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      stall = wv[0] && (wcnt < wstall);
      if (stall) wcnt++;
      wrdy = !stall;
      rst  = (c == rst_at);
      d    = (k < nw) ? fifo[k] : 32'd0;
      rdy  = (k < nw) && (!toggle || (c % 2 == 0));
      #1;
      scan_tie();
      if (rst) scan_rst();
      for (int i = 0; i < 7; i++) begin
        if (rv[i] && wv[i]) conflict = 1'b1;
        if (rv[i] && rdy) pop_cnt[i]++;
        if (wv[i] && wrdy) begin
          if (push_cnt[i] < 2) pval[i][push_cnt[i]] = od[i];
          if (pcyc[i] < 0) pcyc[i] = c;
          push_cnt[i]++;
        end
        if (vl[i]) vcnt[i]++;
      end
      if (wv[0]) begin
        if (wseen && od[0] !== wfirst) unstable = 1'b1;
        if (!wseen) begin wseen = 1'b1; wfirst = od[0]; end
      end
      if (vl[0] && vfirst < 0) vfirst = c;
      if (rv[master] && rdy) k++;
    end
    rst = 1'b0;
  endtask

  initial begin
    set_vec(0, 32'd1, 32'd2, 32'd3, 32'd4,
               32'd10, 32'd10, 32'd1, 32'd4, 32'd4);
    set_vec(1, 32'd200, 32'd100, 32'd50, 32'd10,
               32'd360, 32'd104, 32'd10, 32'd200, 32'd148);
    set_vec(2, 32'd7, 32'd3, 32'd9, 32'd5,
               32'd24, 32'd24, 32'd3, 32'd9, 32'd8);
    set_vec(3, 32'hF0, 32'h0F, 32'hFF, 32'h01,
               32'h1FF, 32'hFF, 32'h01, 32'hFF, 32'h01);
    set_vec(4, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000, 32'h8000_0000,
               32'h0, 32'h0, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // Table vectors: all operators, no stalls
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < 4; j++) fifo[j] = vt[v].d[j];
      run(4, 12, 0, 1'b0, 0, -1);
      chk($sformatf("v%0d_push_cnt", v), push_cnt[0], 1);
      chk($sformatf("v%0d_push_cycle", v), pcyc[0], 5);
      chk($sformatf("v%0d_valid_cycle", v), vfirst, 6);
      chk($sformatf("v%0d_pop_cnt", v), pop_cnt[0], 4);
      for (int i = 0; i < 5; i++)
        chk($sformatf("v%0d_result_u%0d", v, i), pval[i][0], vt[v].e[i]);
      chk($sformatf("v%0d_cont_result", v), pval[5][0], vt[v].e[0]);
      chk($sformatf("v%0d_cont_valid_pulses", v), vcnt[5], 1);
      chk($sformatf("v%0d_n1_result", v), pval[6][0], vt[v].d[0]);
      chk($sformatf("v%0d_n1_push_cycle", v), pcyc[6], 2);
      chk($sformatf("v%0d_pop_push_overlap", v), conflict, 0);
      chk($sformatf("v%0d_tieoffs", v), tie_bad, 0);
      chk($sformatf("v%0d_rst_outputs", v), rst_bad, 0);
    end

    // Input toggling ready, output stalled three cycles in WRITE
    for (int j = 0; j < 4; j++) fifo[j] = j + 1;
    run(4, 20, 0, 1'b1, 3, -1);
    chk("stall_pop_cnt", pop_cnt[0], 4);
    chk("stall_push_cnt", push_cnt[0], 1);
    chk("stall_result", pval[0][0], 10);
    chk("stall_data_stable", unstable, 0);
    chk("stall_push_cycle", pcyc[0], 12);
    chk("stall_overlap", conflict, 0);

    // Continuous mode over two frames
    for (int j = 0; j < 8; j++) fifo[j] = j + 1;
    run(8, 16, 5, 1'b0, 0, -1);
    chk("cont_push_cnt", push_cnt[5], 2);
    chk("cont_first", pval[5][0], 10);
    chk("cont_second", pval[5][1], 26);
    chk("cont_valid_pulses", vcnt[5], 2);
    chk("cont_pop_cnt", pop_cnt[5], 8);
    chk("cont_back_in_read", rv[5], 1);
    chk("oneshot_push_cnt", push_cnt[0], 1);
    chk("oneshot_valid_held", vl[0], 1);

    // Reset after two pops discards the partial frame
    fifo[0] = 1; fifo[1] = 2; fifo[2] = 5; fifo[3] = 6; fifo[4] = 7; fifo[5] = 8;
    run(6, 16, 0, 1'b0, 0, 3);
    chk("midrst_push_cnt", push_cnt[0], 1);
    chk("midrst_result", pval[0][0], 26);
    chk("midrst_push_cycle", pcyc[0], 9);
    chk("midrst_pop_cnt", pop_cnt[0], 6);
    chk("midrst_rst_outputs", rst_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
